// File: rtl/spi_master_req_arb_pkg.sv
// Shared types for the SPI master request arbiter: the client descriptor and the
// sequencer state encoding.
package spi_arb_pkg;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] addr;
        logic [5:0]  cmd_len;
        logic [5:0]  addr_len;
        logic [15:0] data_len;
        logic [15:0] dummy;
        logic [3:0]  csreg;
        logic [3:0]  op;        // {qwr, qrd, wr, rd}
    } spi_desc_t;

    localparam int DESC_W = 116;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE
    } arb_state_t;

    function automatic logic op_is_onehot(input logic [3:0] op);
        return (op != 4'b0000) && ((op & (op - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/spi_master_req_arb_if.sv
// Bundle between the arbiter and the shared SPI controller plus its TX/RX FIFOs.
// The arbiter side uses the master modport, the controller side the slave modport.
interface spi_master_req_arb_if;

    logic [31:0] spi_cmd;
    logic [31:0] spi_addr;
    logic [5:0]  spi_cmd_len;
    logic [5:0]  spi_addr_len;
    logic [15:0] spi_data_len;
    logic [15:0] spi_dummy_rd;
    logic [15:0] spi_dummy_wr;
    logic [3:0]  spi_csreg;
    logic        spi_rd;
    logic        spi_wr;
    logic        spi_qrd;
    logic        spi_qwr;
    logic        spi_swrst;
    logic [31:0] spi_data_tx;
    logic        spi_data_tx_valid;
    logic        spi_data_tx_ready;
    logic [31:0] spi_data_rx;
    logic        spi_data_rx_valid;
    logic        spi_data_rx_ready;
    logic        spi_eot;

    modport master (
        output spi_cmd, spi_addr, spi_cmd_len, spi_addr_len, spi_data_len,
        output spi_dummy_rd, spi_dummy_wr, spi_csreg,
        output spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst,
        output spi_data_tx, spi_data_tx_valid, spi_data_rx_ready,
        input  spi_data_tx_ready, spi_data_rx, spi_data_rx_valid, spi_eot
    );

    modport slave (
        input  spi_cmd, spi_addr, spi_cmd_len, spi_addr_len, spi_data_len,
        input  spi_dummy_rd, spi_dummy_wr, spi_csreg,
        input  spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst,
        input  spi_data_tx, spi_data_tx_valid, spi_data_rx_ready,
        output spi_data_tx_ready, spi_data_rx, spi_data_rx_valid, spi_eot
    );

endinterface

// File: rtl/spi_master_req_arb_picker.sv
// Combinational round-robin picker: first active request at or after ptr,
// scanning cyclically, as a one-hot grant plus its index.
module spi_rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int k;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_req_arb.sv
// Round-robin arbiter/sequencer sharing one SPI controller and FIFO pair among
// NUM_REQ clients. Optional busy watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_master_req_arb
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int TIMEOUT_W = 20
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DESC_W-1:0] desc_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      err_o,
    input  logic [NUM_REQ*32-1:0]     tx_data_i,
    input  logic [NUM_REQ-1:0]        tx_valid_i,
    output logic [NUM_REQ-1:0]        tx_ready_o,
    output logic [31:0]               rx_data_o,
    output logic [NUM_REQ-1:0]        rx_valid_o,
    input  logic [NUM_REQ-1:0]        rx_ready_i,
    output logic                      busy_o,
    spi_master_req_arb_if.master      spi
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               err_q;
    spi_desc_t          desc_q;
    spi_desc_t          sel_desc;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               load;
    logic               op_ok;
    logic               timeout_hit;

    spi_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        sel_desc = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_gnt[k]) begin
                sel_desc = desc_i[k*DESC_W +: DESC_W];
            end
        end
    end

    assign op_ok = op_is_onehot(desc_q.op);

`ifdef SPI_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog_q;

    // Watchdog restarts while issuing, so it counts only cycles spent in BUSY.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wdog_q <= '0;
        end else if (state_q == ISSUE) begin
            wdog_q <= '0;
        end else if (state_q == BUSY) begin
            wdog_q <= wdog_q + TIMEOUT_W'(1);
        end
    end

    assign timeout_hit = (state_q == BUSY) && !spi.spi_eot && (wdog_q == '1);
`else
    assign timeout_hit = 1'b0;
`endif

    assign spi.spi_swrst = timeout_hit;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        ack_o       = '0;
        err_o       = 1'b0;
        spi.spi_rd  = 1'b0;
        spi.spi_wr  = 1'b0;
        spi.spi_qrd = 1'b0;
        spi.spi_qwr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                spi.spi_rd  = op_ok & desc_q.op[0];
                spi.spi_wr  = op_ok & desc_q.op[1];
                spi.spi_qrd = op_ok & desc_q.op[2];
                spi.spi_qwr = op_ok & desc_q.op[3];
                state_d     = op_ok ? BUSY : DONE;
            end
            BUSY: begin
                if (spi.spi_eot || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack_o   = gnt_q;
                err_o   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant, owner and descriptor are captured together so the config outputs
    // stay stable from ISSUE through DONE and hold their value while idle.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
            desc_q   <= '0;
        end else begin
            if (load) begin
                gnt_q   <= pick_gnt;
                owner_q <= pick_idx;
                desc_q  <= sel_desc;
            end
            if ((state_q == ISSUE) && !op_ok) begin
                err_q <= 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if (state_q == DONE) begin
                gnt_q    <= '0;
                err_q    <= 1'b0;
                rr_ptr_q <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q != IDLE);

    assign spi.spi_cmd      = desc_q.cmd;
    assign spi.spi_addr     = desc_q.addr;
    assign spi.spi_cmd_len  = desc_q.cmd_len;
    assign spi.spi_addr_len = desc_q.addr_len;
    assign spi.spi_data_len = desc_q.data_len;
    assign spi.spi_csreg    = desc_q.csreg;
    assign spi.spi_dummy_rd = (desc_q.op[0] | desc_q.op[2]) ? desc_q.dummy : 16'd0;
    assign spi.spi_dummy_wr = (desc_q.op[1] | desc_q.op[3]) ? desc_q.dummy : 16'd0;

    // FIFO ports follow the one-hot grant; everything is quiet with no owner.
    always_comb begin
        spi.spi_data_tx       = '0;
        spi.spi_data_tx_valid = 1'b0;
        spi.spi_data_rx_ready = 1'b0;
        tx_ready_o            = '0;
        rx_valid_o            = '0;
        rx_data_o             = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) begin
                spi.spi_data_tx       = tx_data_i[k*32 +: 32];
                spi.spi_data_tx_valid = tx_valid_i[k];
                spi.spi_data_rx_ready = rx_ready_i[k];
                tx_ready_o[k]         = spi.spi_data_tx_ready;
                rx_valid_o[k]         = spi.spi_data_rx_valid;
                rx_data_o             = spi.spi_data_rx;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_req_arb.sv
// Bench for spi_master_req_arb: descriptor table, round-robin, data steering,
// watchdog (SPI_ARB_TIMEOUT_EN) and mid-transfer reset, with an ack scoreboard.
module tb_spi_master_req_arb;
    import spi_arb_pkg::*;

    localparam int NUM_REQ = 3;

    typedef struct {
        int          client;
        logic [3:0]  op;
        logic [31:0] cmd;
        logic [31:0] addr;
        logic [5:0]  cmd_len;
        logic [15:0] data_len;
        logic [15:0] dummy;
        logic [3:0]  csreg;
        logic [2:0]  exp_gnt;
        logic [3:0]  exp_strobe;
        logic        exp_err;
        logic [15:0] exp_dummy_rd;
        logic [15:0] exp_dummy_wr;
    } vec_t;

    typedef struct {
        int   owner;
        logic err;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_i = '0;
    logic [NUM_REQ*DESC_W-1:0] desc_i = '0;
    logic [NUM_REQ-1:0]        gnt_o, ack_o, tx_ready_o, rx_valid_o;
    logic                      err_o, busy_o;
    logic [NUM_REQ*32-1:0]     tx_data_i = '0;
    logic [NUM_REQ-1:0]        tx_valid_i = '0;
    logic [NUM_REQ-1:0]        rx_ready_i = '0;
    logic [31:0]               rx_data_o;

    spi_master_req_arb_if spi_if ();

    spi_master_req_arb #(
        .NUM_REQ   (NUM_REQ),
        .TIMEOUT_W (4)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .req_i         (req_i),
        .desc_i        (desc_i),
        .gnt_o         (gnt_o),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .busy_o        (busy_o),
        .spi           (spi_if)
    );

    int   total = 0;
    int   bad = 0;
    sb_t  sb_q[$];
    sb_t  sb_item;
    vec_t vecs[6];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return {spi_if.spi_qwr, spi_if.spi_qrd, spi_if.spi_wr, spi_if.spi_rd};
    endfunction

    task automatic set_desc(input int c, input logic [3:0] op, input logic [31:0] cmd,
                            input logic [31:0] addr, input logic [5:0] cmd_len,
                            input logic [15:0] data_len, input logic [15:0] dummy,
                            input logic [3:0] csreg);
        spi_desc_t d;
        d          = '0;
        d.cmd      = cmd;
        d.addr     = addr;
        d.cmd_len  = cmd_len;
        d.addr_len = 6'd24;
        d.data_len = data_len;
        d.dummy    = dummy;
        d.csreg    = csreg;
        d.op       = op;
        desc_i[c*DESC_W +: DESC_W] = d;
    endtask

    // Scoreboard: every completion pulse must match the oldest expected owner/err.
    always @(negedge clk) begin
        if (ack_o != '0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_unexpected_ack: got ack=%b, want none", ack_o);
            end else begin
                sb_item = sb_q.pop_front();
                check_output("sb_ack_owner", 64'(ack_o), 64'(1 << sb_item.owner));
                check_output("sb_err", 64'(err_o), 64'(sb_item.err));
            end
        end
    end

    task automatic apply_stimulus(input vec_t v);
        set_desc(v.client, v.op, v.cmd, v.addr, v.cmd_len, v.data_len, v.dummy, v.csreg);
        req_i[v.client] = 1'b1;
        sb_q.push_back('{v.client, v.exp_err});
        tick();
        check_output("vec_gnt", 64'(gnt_o), 64'(v.exp_gnt));
        check_output("vec_strobe", 64'(strobes()), 64'(v.exp_strobe));
        check_output("vec_cmd", 64'(spi_if.spi_cmd), 64'(v.cmd));
        check_output("vec_addr", 64'(spi_if.spi_addr), 64'(v.addr));
        check_output("vec_addr_len", 64'(spi_if.spi_addr_len), 64'd24);
        check_output("vec_cmd_len", 64'(spi_if.spi_cmd_len), 64'(v.cmd_len));
        check_output("vec_data_len", 64'(spi_if.spi_data_len), 64'(v.data_len));
        check_output("vec_dummy_rd", 64'(spi_if.spi_dummy_rd), 64'(v.exp_dummy_rd));
        check_output("vec_dummy_wr", 64'(spi_if.spi_dummy_wr), 64'(v.exp_dummy_wr));
        check_output("vec_csreg", 64'(spi_if.spi_csreg), 64'(v.csreg));
        check_output("vec_busy", 64'(busy_o), 64'd1);
        if (v.exp_err) begin
            tick();
            check_output("vec_err_ack", 64'(ack_o), 64'(v.exp_gnt));
            check_output("vec_err_flag", 64'(err_o), 64'd1);
        end else begin
            tick();
            check_output("vec_strobe_once", 64'(strobes()), 64'd0);
            tick();
            spi_if.spi_eot = 1'b0;
            tick();
            spi_if.spi_eot = 1'b1;
            tick();
            spi_if.spi_eot = 1'b0;
            check_output("vec_ack", 64'(ack_o), 64'(v.exp_gnt));
            check_output("vec_ok_err", 64'(err_o), 64'd0);
        end
        req_i[v.client] = 1'b0;
        tick();
        check_output("vec_idle_gnt", 64'(gnt_o), 64'd0);
        check_output("vec_idle_busy", 64'(busy_o), 64'd0);
        check_output("vec_cfg_hold", 64'(spi_if.spi_cmd), 64'(v.cmd));
    endtask

    initial begin
        int order[4];
        logic [31:0] words[4];
        int n;
        order = '{0, 1, 2, 0};
        words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

        vecs[0] = '{1, 4'b0001, 32'h0000_000B, 32'h0001_0000, 6'd8, 16'd32,  16'd0, 4'b0001, 3'b010, 4'b0001, 1'b0, 16'd0, 16'd0};
        vecs[1] = '{0, 4'b0010, 32'h0000_0002, 32'h0000_1234, 6'd8, 16'd64,  16'd5, 4'b0010, 3'b001, 4'b0010, 1'b0, 16'd0, 16'd5};
        vecs[2] = '{2, 4'b0100, 32'h0000_006B, 32'h00AB_CDEF, 6'd8, 16'd256, 16'd8, 4'b0100, 3'b100, 4'b0100, 1'b0, 16'd8, 16'd0};
        vecs[3] = '{2, 4'b1000, 32'h0000_0032, 32'h0000_0040, 6'd8, 16'd128, 16'd3, 4'b1000, 3'b100, 4'b1000, 1'b0, 16'd0, 16'd3};
        vecs[4] = '{0, 4'b0011, 32'h0000_00FF, 32'h0000_0000, 6'd8, 16'd8,   16'd0, 4'b0001, 3'b001, 4'b0000, 1'b1, 16'd0, 16'd0};
        vecs[5] = '{1, 4'b0000, 32'h0000_00AA, 32'h0000_0000, 6'd8, 16'd8,   16'd0, 4'b0001, 3'b010, 4'b0000, 1'b1, 16'd0, 16'd0};

        spi_if.spi_eot           = 1'b0;
        spi_if.spi_data_tx_ready = 1'b0;
        spi_if.spi_data_rx       = '0;
        spi_if.spi_data_rx_valid = 1'b0;

        tick();
        tick();
        check_output("rst_gnt", 64'(gnt_o), 64'd0);
        check_output("rst_busy", 64'(busy_o), 64'd0);
        check_output("rst_ack", 64'(ack_o), 64'd0);
        check_output("rst_strobes", 64'(strobes()), 64'd0);
        check_output("rst_swrst", 64'(spi_if.spi_swrst), 64'd0);
        check_output("rst_cmd", 64'(spi_if.spi_cmd), 64'd0);
        check_output("rst_tx_valid", 64'(spi_if.spi_data_tx_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Continuous requests from all clients straight out of reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < NUM_REQ; c++) begin
            set_desc(c, 4'b0001, 32'h03, 32'h0, 6'd8, 16'd32, 16'd0, 4'b0001);
        end
        for (int t = 0; t < 4; t++) begin
            sb_q.push_back('{order[t], 1'b0});
        end
        req_i = 3'b111;
        for (int t = 0; t < 4; t++) begin
            tick();
            check_output("rr_gnt", 64'(gnt_o), 64'(1 << order[t]));
            check_output("rr_rd_strobe", 64'(spi_if.spi_rd), 64'd1);
            tick();
            spi_if.spi_eot = 1'b1;
            tick();
            spi_if.spi_eot = 1'b0;
            check_output("rr_ack", 64'(ack_o), 64'(1 << order[t]));
            if (t == 3) begin
                req_i = '0;
            end
            tick();
            check_output("rr_idle_gap", 64'({busy_o, gnt_o}), 64'd0);
        end

        // Client 2 streams four TX words; other clients present junk that must not leak.
        set_desc(2, 4'b1000, 32'h32, 32'h100, 6'd8, 16'd128, 16'd0, 4'b0100);
        sb_q.push_back('{2, 1'b0});
        req_i[2] = 1'b1;
        tick();
        check_output("tx_gnt", 64'(gnt_o), 64'b100);
        check_output("tx_qwr", 64'(spi_if.spi_qwr), 64'd1);
        tick();
        spi_if.spi_data_tx_ready = 1'b1;
        spi_if.spi_data_rx_valid = 1'b1;
        tx_valid_i = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tx_data_i = {words[i], 32'hBAD1_0001, 32'hBAD0_0000};
            rx_ready_i = (i % 2 == 1) ? 3'b100 : 3'b011;
            spi_if.spi_data_rx = 32'hC0DE_0000 + i;
            #1;
            check_output("tx_word", 64'(spi_if.spi_data_tx), 64'(words[i]));
            check_output("tx_valid", 64'(spi_if.spi_data_tx_valid), 64'd1);
            check_output("tx_ready_route", 64'(tx_ready_o), 64'b100);
            check_output("rx_valid_route", 64'(rx_valid_o), 64'b100);
            check_output("rx_ready_route", 64'(spi_if.spi_data_rx_ready), 64'(i % 2));
            check_output("rx_data", 64'(rx_data_o), 64'(32'hC0DE_0000 + i));
            tick();
        end
        spi_if.spi_eot = 1'b1;
        tick();
        spi_if.spi_eot = 1'b0;
        check_output("tx_ack", 64'(ack_o), 64'b100);
        req_i[2] = 1'b0;
        tick();
        check_output("tx_release_valid", 64'(spi_if.spi_data_tx_valid), 64'd0);
        check_output("tx_release_ready", 64'(tx_ready_o), 64'd0);
        check_output("rx_release_valid", 64'(rx_valid_o), 64'd0);
        check_output("rx_release_ready", 64'(spi_if.spi_data_rx_ready), 64'd0);
        tx_valid_i = '0;
        rx_ready_i = '0;
        spi_if.spi_data_tx_ready = 1'b0;
        spi_if.spi_data_rx_valid = 1'b0;

        // No end-of-transfer from the controller.
        set_desc(1, 4'b0001, 32'h0B, 32'h0, 6'd8, 16'd32, 16'd0, 4'b0001);
        req_i[1] = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        sb_q.push_back('{1, 1'b1});
        tick();
        check_output("wd_gnt", 64'(gnt_o), 64'b010);
        n = 0;
        while (!spi_if.spi_swrst && n < 100) begin
            tick();
            n++;
        end
        check_output("wd_busy_cycles", 64'(n - 1), 64'd15);
        check_output("wd_swrst", 64'(spi_if.spi_swrst), 64'd1);
        tick();
        check_output("wd_ack", 64'(ack_o), 64'b010);
        check_output("wd_err", 64'(err_o), 64'd1);
        check_output("wd_swrst_once", 64'(spi_if.spi_swrst), 64'd0);
`else
        sb_q.push_back('{1, 1'b0});
        tick();
        check_output("wd_gnt", 64'(gnt_o), 64'b010);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n++;
        end
        check_output("nowd_busy", 64'(busy_o), 64'd1);
        check_output("nowd_swrst", 64'(spi_if.spi_swrst), 64'd0);
        check_output("nowd_gnt", 64'(gnt_o), 64'b010);
        spi_if.spi_eot = 1'b1;
        tick();
        spi_if.spi_eot = 1'b0;
        check_output("nowd_ack", 64'(ack_o), 64'b010);
`endif
        req_i[1] = 1'b0;
        tick();

        // Reset in the middle of a transfer; pointer would otherwise favour client 2.
        req_i[1] = 1'b1;
        sb_q.push_back('{1, 1'b0});
        tick();
        check_output("mid_gnt", 64'(gnt_o), 64'b010);
        tick();
        check_output("mid_busy", 64'(busy_o), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_gnt", 64'(gnt_o), 64'd0);
        check_output("mid_rst_busy", 64'(busy_o), 64'd0);
        check_output("mid_rst_strobes", 64'({ack_o, strobes()}), 64'd0);
        sb_q.delete();
        req_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
        set_desc(2, 4'b0001, 32'h0B, 32'h0, 6'd8, 16'd32, 16'd0, 4'b0100);
        sb_q.push_back('{1, 1'b0});
        req_i = 3'b110;
        tick();
        check_output("post_rst_gnt", 64'(gnt_o), 64'b010);
        tick();
        spi_if.spi_eot = 1'b1;
        tick();
        spi_if.spi_eot = 1'b0;
        check_output("post_rst_ack", 64'(ack_o), 64'b010);
        req_i = '0;
        tick();
        tick();
        check_output("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
